// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 14-bit binary to 4-digit BCD converter (double dabble)
// with saturation to SAT_VALUE for inputs above 9999.
module bin_to_bcd_seq #(
  parameter logic [15:0] SAT_VALUE = 16'h9999
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [15:0] bcd_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [13:0] r_sr;
  logic [15:0] r_scr, w_adj;
  logic [3:0]  r_cnt;
  logic        r_ovf;
  for (genvar g = 0; g < 4; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? r_scr[4*g +: 4] + 4'd3 : r_scr[4*g +: 4];
  end
  always_ff @(posedge CLK100MHZ or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  // SHIFT spends 14 cycles shifting and one more cycle publishing the finished scratch word
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? SHIFT : IDLE;
      SHIFT:   w_next = (r_cnt == 4'd14) ? DONE : SHIFT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK100MHZ or posedge reset)
    if (reset) begin
      r_sr     <= '0;
      r_scr    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      overflow <= 1'b0;
      bcd_out  <= '0;
    end else if (r_state == IDLE && start) begin
      r_sr  <= bin_in;
      r_scr <= '0;
      r_cnt <= '0;
      r_ovf <= bin_in > 14'd9999;
    end else if (r_state == SHIFT) begin
      if (r_cnt == 4'd14) begin
        bcd_out  <= r_ovf ? SAT_VALUE : r_scr;
        overflow <= r_ovf;
      end else begin
        {r_scr, r_sr} <= {w_adj[14:0], r_sr, 1'b0};
        r_cnt         <= r_cnt + 4'd1;
      end
    end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed checks of latency, boundaries, back-to-back starts,
// mid-conversion reset and a strided input sweep.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [13:0] bin_in;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;
  int          n_chk = 0, n_bad = 0;

  bin_to_bcd_seq dut (
    .CLK100MHZ(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input int v);
    return (v > 9999) ? 16'h9999 :
      {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic conv(input logic [13:0] v);
    logic [15:0] prev;
    int lat, nb;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    prev   = bcd_out;
    @(posedge clk);
    #1 start = 1'b0;
    bin_in = ~v;
    lat = 0;
    nb  = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1 lat++;
      if (busy) nb++;
      if (lat == 8) chk("hold_shift", bcd_out, prev);
    end
    chk("latency", lat, 15);
    chk("busy_cycles", nb, 16);
    chk("bcd", bcd_out, model(int'(v)));
    chk("ovf", overflow, v > 14'd9999);
    @(posedge clk);
    #1 chk("back_idle", {busy, done}, 2'b00);
  endtask

  initial begin
    int seen;
    logic [13:0] f;
    reset = 1'b1;
    start = 1'b0;
    bin_in = '0;
    #1;
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("idle_hold", {busy, done, overflow, bcd_out}, 19'h0);

    conv(14'd1234);
    conv(14'd0);
    conv(14'd9999);
    conv(14'd10000);
    chk("sat_val", bcd_out, 16'h9999);
    conv(14'd42);
    chk("after_sat", {overflow, bcd_out}, 17'h00042);
    conv(14'd16383);
    conv(14'd8);

    // start held high: sampling edges at e = 0, 17, 34; done after edges 15, 32, 49
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      bin_in = 14'((e * 397 + 123) % 16384);
      @(posedge clk);
      #1 chk("b2b_done", done, (e % 17) == 15);
      if (done) begin
        f = 14'(((e - 15) * 397 + 123) % 16384);
        chk("b2b_bcd", bcd_out, model(int'(f)));
        chk("b2b_ovf", overflow, f > 14'd9999);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("b2b_stop", busy, 1'b0);

    conv(14'd1234);
    @(negedge clk);
    bin_in = 14'd5678;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_bcd", bcd_out, 16'h0000);
    chk("abort_ovf", overflow, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) seen++;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_keep", bcd_out, 16'h0000);
    conv(14'd5678);

    for (int v = 0; v < 16384; v += 7) conv(14'(v));
    conv(14'd9998);
    conv(14'd10001);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
